// File: rtl/strobe_period_checker.sv
// ============================================================================
// Module   : strobe_period_checker
// Purpose  : Measures en-qualified intervals between strobes, declares lock
//            after a run of in-tolerance periods, flags bad or missing strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_period_checker #(
    parameter int N          = 64,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int W          = $clog2(2*N+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         stb,
    output logic [W-1:0] period,
    output logic         period_vld,
    output logic         locked,
    output logic         err_period,
    output logic         err_timeout
);

    localparam int              MW           = $clog2(LOCK_COUNT+1);
    localparam logic [W:0]      c_m_lo       = (W+1)'(N - TOL);
    localparam logic [W:0]      c_m_hi       = (W+1)'(N + TOL);
    localparam logic [W-1:0]    c_cnt_max    = W'(2*N - 1);
    localparam logic [MW-1:0]   c_lock_count = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;
    logic [W-1:0]    period_q, period_d;
    logic            period_vld_q, period_vld_d;
    logic            locked_q, locked_d;
    logic            err_period_q, err_period_d;
    logic            err_timeout_q, err_timeout_d;

    logic [W:0]      w_m;
    logic            w_match;
    logic            w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            match_cnt_q   <= '0;
            period_q      <= '0;
            period_vld_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_period_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            match_cnt_q   <= match_cnt_d;
            period_q      <= period_d;
            period_vld_q  <= period_vld_d;
            locked_q      <= locked_d;
            err_period_q  <= err_period_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        // Interval includes the strobe cycle itself when it is en-qualified
        w_m       = {1'b0, cnt_q} + {{W{1'b0}}, en};
        w_match   = (w_m >= c_m_lo) && (w_m <= c_m_hi);
        w_timeout = (state_q != S_IDLE) && (cnt_q == c_cnt_max) && en && !stb;

        state_d       = state_q;
        cnt_d         = cnt_q;
        match_cnt_d   = match_cnt_q;
        period_d      = period_q;
        period_vld_d  = 1'b0;
        err_period_d  = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (stb) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE, S_LOCKED: begin
                if (stb) begin
                    cnt_d        = '0;
                    period_d     = w_m[W-1:0];
                    period_vld_d = 1'b1;
                    if (w_match) begin
                        if (match_cnt_q != c_lock_count) begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                        if (match_cnt_d == c_lock_count) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        err_period_d = 1'b1;
                        match_cnt_d  = '0;
                        state_d      = S_MEASURE;
                    end
                end else if (w_timeout) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    match_cnt_d   = '0;
                    state_d       = S_IDLE;
                end else if (en) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        locked_d = (state_d == S_LOCKED);
    end

    assign period      = period_q;
    assign period_vld  = period_vld_q;
    assign locked      = locked_q;
    assign err_period  = err_period_q;
    assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_strobe_period_checker.sv
// ============================================================================
// Module   : tb_strobe_period_checker
// Purpose  : Table-driven, scoreboarded bench for strobe_period_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_strobe_period_checker;

    localparam int W = 8;

    typedef struct {
        int gap;     // clocks from previous event to this one (event on last)
        bit stb;     // strobe on final cycle (0 = expect timeout there)
        bit tog;     // en toggles, high on even cycle indices
        int period;
        bit vld;
        bit errp;
        bit errt;
        bit lck;
    } vec_t;

    typedef struct {
        bit           sel;
        logic [W-1:0] period;
        bit           vld;
        bit           errp;
        bit           errt;
        bit           lck;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         stb0, en0, stb1, en1;
    logic [W-1:0] period0, period1;
    logic         vld0, vld1, lck0, lck1, ep0, ep1, et0, et1;

    int           n_assert = 0;
    int           n_fail   = 0;
    bit           sel      = 1'b0;
    int           cur_period;
    bit           cur_lck;
    exp_t         sbq[$];
    vec_t         tv0[$];
    vec_t         tv1[$];
    vec_t         tv2[$];

    always #5 clk = ~clk;

    strobe_period_checker #(.N(64), .TOL(0), .LOCK_COUNT(4)) u_dut0 (
        .clk(clk), .rst(rst), .en(en0), .stb(stb0),
        .period(period0), .period_vld(vld0), .locked(lck0),
        .err_period(ep0), .err_timeout(et0)
    );

    strobe_period_checker #(.N(64), .TOL(2), .LOCK_COUNT(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .stb(stb1),
        .period(period1), .period_vld(vld1), .locked(lck1),
        .err_period(ep1), .err_timeout(et1)
    );

    function automatic vec_t mk(int gap, bit s, bit tog, int p, bit v, bit ep, bit et, bit lk);
        vec_t r;
        r.gap = gap; r.stb = s; r.tog = tog; r.period = p;
        r.vld = v; r.errp = ep; r.errt = et; r.lck = lk;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pending();
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            if (!x.sel) begin
                chk("period",      32'(period0), 32'(x.period));
                chk("period_vld",  32'(vld0),    32'(x.vld));
                chk("err_period",  32'(ep0),     32'(x.errp));
                chk("err_timeout", 32'(et0),     32'(x.errt));
                chk("locked",      32'(lck0),    32'(x.lck));
            end else begin
                chk("tol_period",      32'(period1), 32'(x.period));
                chk("tol_period_vld",  32'(vld1),    32'(x.vld));
                chk("tol_err_period",  32'(ep1),     32'(x.errp));
                chk("tol_err_timeout", 32'(et1),     32'(x.errt));
                chk("tol_locked",      32'(lck1),    32'(x.lck));
            end
        end
    endtask

    task automatic step(input bit s, input bit e, input exp_t x);
        @(negedge clk);
        check_pending();
        stb0 = sel ? 1'b0 : s;
        en0  = sel ? 1'b0 : e;
        stb1 = sel ? s : 1'b0;
        en1  = sel ? e : 1'b0;
        sbq.push_back(x);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t q;
        exp_t ev;
        bit   e;
        for (int k = 1; k <= v.gap; k++) begin
            e = v.tog ? (k % 2 == 0) : 1'b1;
            if (k == v.gap) begin
                ev.sel = sel; ev.period = W'(v.period); ev.vld = v.vld;
                ev.errp = v.errp; ev.errt = v.errt; ev.lck = v.lck;
                cur_period = v.period;
                cur_lck    = v.lck;
                step(v.stb, e, ev);
            end else begin
                q.sel = sel; q.period = W'(cur_period); q.vld = 1'b0;
                q.errp = 1'b0; q.errt = 1'b0; q.lck = cur_lck;
                step(1'b0, e, q);
            end
        end
    endtask

    initial begin
        // Main table: lock, slip, relock, timeout, en toggling, corner intervals
        tv0.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 0));
        tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));
        tv0.push_back(mk(60, 1, 0, 60, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 0));
        tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));
        tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));
        tv0.push_back(mk(128, 0, 0, 64, 0, 0, 1, 0));
        tv0.push_back(mk(10, 1, 0, 64, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tv0.push_back(mk(128, 1, 1, 64, 1, 0, 0, 0));
        tv0.push_back(mk(128, 1, 1, 64, 1, 0, 0, 1));
        tv0.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
        tv0.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0));
        tv0.push_back(mk(128, 1, 0, 128, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 0));
        tv0.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));

        // After an asynchronous reset: start strobe, then four good intervals
        tv2.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tv2.push_back(mk(64, 1, 0, 64, 1, 0, 0, 0));
        tv2.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));

        // TOL=2: 62 and 66 match, 67 fails and restarts the match run
        tv1.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0));
        tv1.push_back(mk(62, 1, 0, 62, 1, 0, 0, 0));
        tv1.push_back(mk(66, 1, 0, 66, 1, 0, 0, 0));
        tv1.push_back(mk(67, 1, 0, 67, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) tv1.push_back(mk(64, 1, 0, 64, 1, 0, 0, 0));
        tv1.push_back(mk(64, 1, 0, 64, 1, 0, 0, 1));

        rst = 1'b1; stb0 = 1'b0; en0 = 1'b0; stb1 = 1'b0; en1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period",      32'(period0), 32'd0);
        chk("rst_period_vld",  32'(vld0),    32'd0);
        chk("rst_locked",      32'(lck0),    32'd0);
        chk("rst_err_period",  32'(ep0),     32'd0);
        chk("rst_err_timeout", 32'(et0),     32'd0);
        chk("rst_tol_period",  32'(period1), 32'd0);
        chk("rst_tol_locked",  32'(lck1),    32'd0);
        rst = 1'b0;

        cur_period = 0; cur_lck = 1'b0; sel = 1'b0;
        foreach (tv0[i]) run_vec(tv0[i]);

        // Pulse reset between clock edges while locked
        @(negedge clk);
        check_pending();
        stb0 = 1'b0; en0 = 1'b0;
        chk("pre_rst_locked", 32'(lck0), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_period",      32'(period0), 32'd0);
        chk("async_rst_period_vld",  32'(vld0),    32'd0);
        chk("async_rst_locked",      32'(lck0),    32'd0);
        chk("async_rst_err_period",  32'(ep0),     32'd0);
        chk("async_rst_err_timeout", 32'(et0),     32'd0);
        #1 rst = 1'b0;

        cur_period = 0; cur_lck = 1'b0;
        foreach (tv2[i]) run_vec(tv2[i]);

        sel = 1'b1; cur_period = 0; cur_lck = 1'b0;
        foreach (tv1[i]) run_vec(tv1[i]);

        @(negedge clk);
        check_pending();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
